// File: rtl/add_sub_pkg.sv
// add_sub_pkg: shared states, mode encodings and overflow helper for serial_add_sub.
package add_sub_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;
  function automatic logic ovf_f(input logic m, input logic a_msb, input logic b_msb, input logic r_msb);
    return ((m == MODE_SUB) ? (a_msb != b_msb) : (a_msb == b_msb)) && (r_msb != a_msb);
  endfunction
endpackage

// File: rtl/add_sub_slice.sv
// add_sub_slice: combinational SLICE-bit ripple chain of one-bit add/sub cells.
module add_sub_slice
  import add_sub_pkg::*;
#(
  parameter int SLICE = 1
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             mode,
  input  logic             c_in,
  output logic [SLICE-1:0] r,
  output logic             c_out
);
  logic [SLICE:0] c;
  assign c[0] = c_in;
  assign c_out = c[SLICE];
  for (genvar i = 0; i < SLICE; i++) begin : g_bit
    assign r[i] = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (mode == MODE_SUB) ? ((~a[i] & b[i]) | (~(a[i] ^ b[i]) & c[i]))
                                       : ((a[i] & b[i]) | ((a[i] ^ b[i]) & c[i]));
  end
endmodule

// File: rtl/serial_add_sub.sv
// serial_add_sub: multi-cycle add/subtract, SLICE bits per clock LSB first, with
// valid/ready handshakes on operands and result.
module serial_add_sub
  import add_sub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SLICE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             mode,
  input  logic             cin,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow,
  output logic             res_valid,
  input  logic             res_ready
);
  localparam int N  = WIDTH / SLICE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  if (WIDTH < 2 || SLICE < 1 || (WIDTH % SLICE) != 0) begin : g_bad_param
    $error("serial_add_sub: WIDTH must be >= 2 and a multiple of SLICE >= 1");
  end
  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, result_q, result_d;
  logic             mode_q, mode_d, c_q, c_d, cout_q, cout_d, ovf_q, ovf_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [SLICE-1:0] r;
  logic             c_nx;
  add_sub_slice #(.SLICE(SLICE)) u_slice (
    .a    (a_q[SLICE-1:0]),
    .b    (b_q[SLICE-1:0]),
    .mode (mode_q),
    .c_in (c_q),
    .r    (r),
    .c_out(c_nx)
  );
  assign start_ready = (state_q == IDLE);
  assign res_valid   = (state_q == DONE);
  assign result      = result_q;
  assign cout        = cout_q;
  assign overflow    = ovf_q;
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    mode_d   = mode_q;
    c_d      = c_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    if (state_q == IDLE && start_valid) begin
      a_d     = op_a;
      b_d     = op_b;
      mode_d  = mode;
      c_d     = cin;
      cnt_d   = '0;
      state_d = RUN;
    end
    if (state_q == RUN) begin
      a_d   = a_q >> SLICE;
      b_d   = b_q >> SLICE;
      acc_d = (acc_q >> SLICE) | (WIDTH'(r) << (WIDTH - SLICE));
      c_d   = c_nx;
      cnt_d = cnt_q + CW'(1);
      // The last slice still sees the operand MSBs in its top bit.
      if (cnt_q == CW'(N - 1)) begin
        state_d  = DONE;
        cnt_d    = '0;
        result_d = acc_d;
        cout_d   = c_nx;
        ovf_d    = ovf_f(mode_q, a_q[SLICE-1], b_q[SLICE-1], r[SLICE-1]);
      end
    end
    if (state_q == DONE && res_ready) state_d = IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      mode_q   <= MODE_ADD;
      c_q      <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      mode_q   <= mode_d;
      c_q      <= c_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end
endmodule

// File: tb/tb_serial_add_sub.sv
// tb_serial_add_sub: directed vectors against SLICE=1 and SLICE=2 instances sharing stimulus.
module tb_serial_add_sub;
  logic       clk = 1'b0;
  logic       rst_n, start_valid, mode, cin, res_ready;
  logic [7:0] op_a, op_b;
  logic       sr1, co1, ov1, rv1, sr2, co2, ov2, rv2;
  logic [7:0] res1, res2;
  int         n_chk = 0;
  int         n_fail = 0;
  always #5 clk = ~clk;
  serial_add_sub #(.WIDTH(8), .SLICE(1)) u_s1 (
    .clk(clk), .rst_n(rst_n), .start_valid(start_valid), .start_ready(sr1),
    .op_a(op_a), .op_b(op_b), .mode(mode), .cin(cin),
    .result(res1), .cout(co1), .overflow(ov1), .res_valid(rv1), .res_ready(res_ready)
  );
  serial_add_sub #(.WIDTH(8), .SLICE(2)) u_s2 (
    .clk(clk), .rst_n(rst_n), .start_valid(start_valid), .start_ready(sr2),
    .op_a(op_a), .op_b(op_b), .mode(mode), .cin(cin),
    .result(res2), .cout(co2), .overflow(ov2), .res_valid(rv2), .res_ready(res_ready)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask
  task automatic run_op(input logic m, input logic [7:0] a, input logic [7:0] b, input logic c,
                        input logic [7:0] er, input logic eco, input logic eov, input bit noise);
    int l1 = 0;
    int l2 = 0;
    @(negedge clk);
    start_valid = 1'b1; mode = m; op_a = a; op_b = b; cin = c;
    @(negedge clk);
    start_valid = 1'b0;
    check("s1_busy_ready", sr1, 0);
    check("s2_busy_ready", sr2, 0);
    check("s1_early_valid", rv1, 0);
    check("s2_early_valid", rv2, 0);
    for (int k = 1; k <= 12; k++) begin
      if (noise) begin
        start_valid = k[0]; op_a = 8'($urandom); op_b = 8'($urandom); mode = ~mode; cin = ~cin;
      end
      @(negedge clk);
      if (rv1 && l1 == 0) l1 = k;
      if (rv2 && l2 == 0) l2 = k;
    end
    start_valid = 1'b0;
    check("s1_latency", l1, 8);
    check("s2_latency", l2, 4);
    check("s1_result", res1, er);
    check("s2_result", res2, er);
    check("s1_cout", co1, eco);
    check("s2_cout", co2, eco);
    check("s1_overflow", ov1, eov);
    check("s2_overflow", ov2, eov);
    check("s1_held_valid", rv1, 1);
    check("s2_held_valid", rv2, 1);
    check("s1_done_ready", sr1, 0);
    check("s2_done_ready", sr2, 0);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check("s1_valid_drop", rv1, 0);
    check("s2_valid_drop", rv2, 0);
    check("s1_idle_ready", sr1, 1);
    check("s2_idle_ready", sr2, 1);
  endtask
  initial begin
    rst_n = 1'b0; start_valid = 1'b0; mode = 1'b0; cin = 1'b0; res_ready = 1'b0;
    op_a = 8'h00; op_b = 8'h00;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check("rst_s1_out", {res1, co1, ov1, rv1, sr1}, {8'h00, 4'b0001});
    check("rst_s2_out", {res2, co2, ov2, rv2, sr2}, {8'h00, 4'b0001});
    run_op(1'b0, 8'h3C, 8'h55, 1'b0, 8'h91, 1'b0, 1'b1, 0);
    run_op(1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 0);
    run_op(1'b0, 8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1, 0);
    run_op(1'b1, 8'h05, 8'h07, 1'b0, 8'hFE, 1'b1, 1'b0, 0);
    run_op(1'b1, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 0);
    run_op(1'b1, 8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0, 0);
    run_op(1'b1, 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 0);
    run_op(1'b0, 8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b0, 1);
    run_op(1'b1, 8'h37, 8'h12, 1'b0, 8'h25, 1'b0, 1'b0, 1);
    // Abort an operation with a one-cycle reset mid-RUN.
    @(negedge clk);
    start_valid = 1'b1; mode = 1'b0; op_a = 8'hC3; op_b = 8'h3C; cin = 1'b1;
    @(negedge clk);
    start_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrun_rst_s1", {res1, co1, ov1, rv1, sr1}, {8'h00, 4'b0001});
    check("midrun_rst_s2", {res2, co2, ov2, rv2, sr2}, {8'h00, 4'b0001});
    run_op(1'b0, 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
